wb_hyperram_arbiter: RTL
========================

WB_HYPERRAM_ARBITER -- requirements
Module: wb_hyperram_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 2, number of Wishbone master ports (legal 1..8).
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter DATA_W, default 32, data width; SEL_W = DATA_W/8.
REQ-004 Parameter TIMEOUT, default 1024, cycles without slave ack before abort (legal 2..65535).
REQ-005 The port list SHALL be as follows; clock and reset are first.
- wb_clk_i  in  1  sole clock, rising edge.
- wb_rst_i  in  1  asynchronous, active-high reset.
- m_cyc_i  in  NUM_MASTERS  per-master cycle.
- m_stb_i  in  NUM_MASTERS  per-master strobe.
- m_we_i  in  NUM_MASTERS  per-master write enable.
- m_sel_i  in  NUM_MASTERS*SEL_W  byte selects, master k at slice k.
- m_addr_i  in  NUM_MASTERS*ADDR_W  addresses, master k at slice k.
- m_dat_i  in  NUM_MASTERS*DATA_W  write data, master k at slice k.
- m_ack_o  out  NUM_MASTERS  per-master acknowledge.
- m_err_o  out  NUM_MASTERS  per-master timeout error.
- m_dat_o  out  DATA_W  read data broadcast to all masters.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to wb_hyperram slave.
- s_sel_o  out  SEL_W; s_addr_o  out  ADDR_W; s_dat_o  out  DATA_W.
- s_ack_i  in  1; s_dat_i  in  DATA_W  from slave.
- grant_o  out  NUM_MASTERS  one-hot current grant, 0 when idle.

Function
REQ-010 FSM states: IDLE, BUSY, ABORT; only the grant index, FSM state, RR pointer and timeout counter are registered.
REQ-011 IDLE: if any m_cyc_i[k]&m_stb_i[k], the arbiter SHALL grant the first requester searching upward from the RR pointer, wrapping modulo NUM_MASTERS, and enter BUSY at the next edge.
REQ-012 On grant to master k, the RR pointer SHALL become (k+1) mod NUM_MASTERS.
REQ-013 In BUSY, s_cyc/stb/we/sel/addr/dat_o SHALL combinationally equal the granted master's inputs; latency request->s_stb_o is exactly 1 cycle.
REQ-014 In IDLE and ABORT, s_cyc_o, s_stb_o and s_we_o SHALL be 0, and s_sel_o, s_addr_o and s_dat_o SHALL be 0.
REQ-015 m_ack_o[k] SHALL equal s_ack_i & BUSY & grant k, combinationally the same cycle; other masters' ack is 0.
REQ-016 m_dat_o SHALL equal s_dat_i at all times.
REQ-017 The grant SHALL be held while the granted master keeps m_cyc_i high, so back-to-back strobes form a locked burst.
REQ-018 When the granted master drops m_cyc_i, s_cyc_o SHALL drop the same cycle and the FSM SHALL return to IDLE at the next edge; re-arbitration occurs in IDLE.
REQ-019 s_ack_i in IDLE or ABORT SHALL be ignored, with no m_ack_o.
REQ-020 The timeout counter SHALL clear on entering BUSY and on every s_ack_i, and increment each BUSY cycle with s_stb_o high and s_ack_i low.
REQ-021 When the counter reaches TIMEOUT-1 with no ack, m_err_o[k] SHALL pulse for that one cycle and the FSM SHALL enter ABORT.
REQ-022 ABORT SHALL last exactly 1 cycle, then go to IDLE.
REQ-023 If ack and timeout coincide, the ack SHALL win: no err, and the counter clears.
REQ-024 With NUM_MASTERS=1 the RR pointer is constant 0 and behaviour is otherwise identical.

Reset
REQ-030 wb_rst_i SHALL asynchronously force the following: FSM to IDLE, RR pointer 0, counter 0, grant_o 0, all m_ack_o/m_err_o/s_* control outputs 0.
REQ-031 Reset asserted mid-transaction SHALL drop s_cyc_o immediately; the first post-reset arbitration starts from master 0.

Structure
REQ-040 A shared package wb_hyperram_pkg SHALL hold the FSM state encoding and the NUM_MASTERS max constant (8).
REQ-041 A sub-module rr_arbiter SHALL compute the next grant from the request vector and pointer; the timeout counter SHALL stay in the top module.
REQ-042 The counter width SHALL be clog2(TIMEOUT).

Verification
REQ-050 Masters 0 and 1 both request at cycle 0 after reset -> grant_o=01 at cycle 1; after master 0 drops cyc, grant_o=10.
REQ-051 Master 1 issues 4 locked strobes writing 0x11111111..0x44444444 at addr 0x100..0x10C -> 4 acks to master 1 only; master 0 stays ungranted; readback returns the same data.
REQ-052 Slave model never acks, TIMEOUT=16 -> m_err_o pulses 1 cycle exactly 16 cycles after s_stb_o rises; s_cyc_o=0 for one cycle; then IDLE.
REQ-053 Ack arrives on cycle 15 of a TIMEOUT=16 wait -> m_ack_o=1, m_err_o stays 0.
REQ-054 Reset asserted while BUSY with master 1 -> s_cyc_o=0 the same cycle; after release, simultaneous requests from masters 0/1 grant master 0.
REQ-055 NUM_MASTERS=4 with all masters requesting continuously, single-beat cycles -> grants cycle 0,1,2,3,0 in order.

Source files
------------

// File: rtl/wb_hyperram_pkg.sv
// Shared definitions for the Wishbone-to-HyperRAM arbiter: FSM encoding,
// the master-count ceiling and an index-width helper.
package wb_hyperram_pkg;

  localparam int unsigned MAX_MASTERS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

  // A single master still needs a one-bit index so vectors never collapse to zero width.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: first active request at or above the pointer,
// wrapping modulo NUM_MASTERS, plus the pointer value that follows that grant.
module rr_arbiter
  import wb_hyperram_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned IDX_W       = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]       ptr_i,
  output logic                   valid_o,
  output logic [IDX_W-1:0]       idx_o,
  output logic [IDX_W-1:0]       ptr_next_o
);

  always_comb begin
    int unsigned      cand;
    logic [IDX_W-1:0] cidx;
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    cidx    = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      cand = (32'(ptr_i) + i) % NUM_MASTERS;
      cidx = IDX_W'(cand);
      if (!valid_o && req_i[cidx]) begin
        valid_o = 1'b1;
        idx_o   = cidx;
      end
    end
  end

  assign ptr_next_o = (idx_o == IDX_W'(NUM_MASTERS - 1)) ? '0 : idx_o + 1'b1;

endmodule

// File: rtl/wb_hyperram_arbiter.sv
// N-master Wishbone arbiter in front of a single wb_hyperram slave, with
// locked bursts while the owner holds cyc and a no-ack timeout abort.
module wb_hyperram_arbiter
  import wb_hyperram_pkg::*;
#(
  parameter  int unsigned NUM_MASTERS = 2,
  parameter  int unsigned ADDR_W      = 32,
  parameter  int unsigned DATA_W      = 32,
  parameter  int unsigned TIMEOUT     = 1024,
  localparam int unsigned SEL_W       = DATA_W / 8
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [NUM_MASTERS-1:0]        m_cyc_i,
  input  logic [NUM_MASTERS-1:0]        m_stb_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS*SEL_W-1:0]  m_sel_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_dat_i,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic [DATA_W-1:0]             m_dat_o,
  output logic                          s_cyc_o,
  output logic                          s_stb_o,
  output logic                          s_we_o,
  output logic [SEL_W-1:0]              s_sel_o,
  output logic [ADDR_W-1:0]             s_addr_o,
  output logic [DATA_W-1:0]             s_dat_o,
  input  logic                          s_ack_i,
  input  logic [DATA_W-1:0]             s_dat_i,
  output logic [NUM_MASTERS-1:0]        grant_o
);

  localparam int unsigned IDX_W = idx_width(NUM_MASTERS);
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  arb_state_e             state_q;
  logic [IDX_W-1:0]       gnt_q;
  logic [IDX_W-1:0]       ptr_q;
  logic [IDX_W-1:0]       ptr_d;
  logic [CNT_W-1:0]       cnt_q;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] gnt_oh;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_valid;
  logic                   busy;
  logic                   own_cyc;
  logic                   own_stb;
  logic                   timeout_hit;

  assign req = m_cyc_i & m_stb_i;

  rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_rr (
    .req_i      (req),
    .ptr_i      (ptr_q),
    .valid_o    (arb_valid),
    .idx_o      (arb_idx),
    .ptr_next_o (ptr_d)
  );

  assign busy    = (state_q == ST_BUSY);
  assign own_cyc = m_cyc_i[gnt_q];
  assign own_stb = m_stb_i[gnt_q];

  // A coincident ack always beats the timeout.
  assign timeout_hit = busy && own_cyc && own_stb && !s_ack_i &&
                       (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    gnt_oh = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      gnt_oh[k] = busy && (gnt_q == IDX_W'(k));
    end
  end

  assign grant_o = gnt_oh;
  assign m_ack_o = gnt_oh & {NUM_MASTERS{s_ack_i}};
  assign m_err_o = gnt_oh & {NUM_MASTERS{timeout_hit}};
  assign m_dat_o = s_dat_i;

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_addr_o = '0;
    s_dat_o  = '0;
    if (busy) begin
      s_cyc_o  = own_cyc;
      s_stb_o  = own_stb;
      s_we_o   = m_we_i[gnt_q];
      s_sel_o  = m_sel_i[gnt_q*SEL_W +: SEL_W];
      s_addr_o = m_addr_i[gnt_q*ADDR_W +: ADDR_W];
      s_dat_o  = m_dat_i[gnt_q*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            state_q <= ST_BUSY;
            gnt_q   <= arb_idx;
            ptr_q   <= ptr_d;
            cnt_q   <= '0;
          end
        end
        ST_BUSY: begin
          if (!own_cyc) begin
            state_q <= ST_IDLE;
          end else if (timeout_hit) begin
            state_q <= ST_ABORT;
          end
          if (s_ack_i || timeout_hit) begin
            cnt_q <= '0;
          end else if (own_stb) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_ABORT: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
